// File: rtl/instruction_register_multi.sv
// Multi-word instruction register: assembles WORDS fetch words into one
// instruction and holds it until acked. Optional: INSTR_REG_MULTI_PARITY_EN.
module instruction_register_multi #(
   parameter int WORD_W = 8,
   parameter int WORDS  = 2
) (
   input  logic                      IRM_clk,
   input  logic                      IRM_rst,
   input  logic [WORD_W-1:0]         IRM_in,
   input  logic                      IRM_wr_en,
   input  logic                      IRM_rd_en,
   input  logic                      IRM_ack,
   input  logic                      IRM_flush,
`ifdef INSTR_REG_MULTI_PARITY_EN
   input  logic                      IRM_par_in,
   output logic                      IRM_par_err,
`endif
   output logic [WORD_W*WORDS-1:0]   IRM_out,
   output logic                      IRM_valid,
   output logic                      IRM_ready,
   output logic [$clog2(WORDS)-1:0]  IRM_idx
);

   localparam int IDX_W = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);
   localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  idx_d;
   logic [IDX_W-1:0]  widx;
   logic              we;
   logic [WORD_W-1:0] slot_q [WORDS];

   // State, index and slot storage registers
   always_ff @(posedge IRM_clk) begin
      if (IRM_rst) begin
         state_q <= FILL;
         idx_q   <= '0;
         for (int k = 0; k < WORDS; k++)
            slot_q[k] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (we)
            slot_q[widx] <= IRM_in;
      end
   end

   // Next-state: flush beats ack/write; ack+write in FULL starts the next fetch
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      we      = 1'b0;
      widx    = idx_q;
      if (IRM_flush) begin
         state_d = FILL;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            FILL: begin
               if (IRM_wr_en) begin
                  we = 1'b1;
                  if (idx_q == LAST) begin
                     idx_d   = '0;
                     state_d = FULL;
                  end else begin
                     idx_d = idx_q + ONE;
                  end
               end
            end
            FULL: begin
               if (IRM_ack) begin
                  state_d = FILL;
                  if (IRM_wr_en) begin
                     we    = 1'b1;
                     widx  = '0;
                     idx_d = ONE;
                  end
               end
            end
            default: begin
               state_d = FILL;
            end
         endcase
      end
   end

   // Outputs: slot 0 lands in the MSBs, bus gated by read enable
   always_comb begin
      IRM_out = '0;
      if (IRM_rd_en) begin
         for (int k = 0; k < WORDS; k++)
            IRM_out[WORD_W*(WORDS-k)-1 -: WORD_W] = slot_q[k];
      end
      IRM_valid = (state_q == FULL);
      IRM_ready = (state_q != FULL) | IRM_ack;
      IRM_idx   = idx_q;
   end

`ifdef INSTR_REG_MULTI_PARITY_EN
   logic par_q;

   // Sticky parity error on any accepted write; cleared by reset or flush
   always_ff @(posedge IRM_clk) begin
      if (IRM_rst)
         par_q <= 1'b0;
      else if (IRM_flush)
         par_q <= 1'b0;
      else if (we && ((^IRM_in) != IRM_par_in))
         par_q <= 1'b1;
   end

   assign IRM_par_err = par_q;
`endif

endmodule
